// File: rtl/frame_scaler_if.sv
// Raster-order source pixel stream into frame_scaler.
//   in_valid : pixel strobe
//   in_sof   : qualifies in_valid, first pixel of a frame
//   in_data  : pixel code
interface frame_scaler_if #(
    parameter int unsigned PIX_BITS = 2
);
    logic                in_valid;
    logic                in_sof;
    logic [PIX_BITS-1:0] in_data;

    modport master (output in_valid, in_sof, in_data);
    modport slave  (input  in_valid, in_sof, in_data);
endinterface

// File: rtl/frame_scaler.sv
// Double-buffered integer-scaling frame scaler for the DVI output path.
// A raster-order pixel stream fills the back buffer; the front buffer is read
// with sync_gen coordinates, scaled by 2^SCALE_LOG2, mapped through a palette.
// Ports:
//   gpuclk, gpuclk_rst_b            : clock, async active-low reset
//   pix (slave)                     : source pixel stream
//   pal_we/pal_addr/pal_data        : palette entry write
//   x, y, hs, vs, border            : raster position and syncs from sync_gen
//   color, hsync, vsync, blank_b    : pipelined display outputs (2 cycles)
//   frame_swapped, frame_dropped    : one-cycle event pulses
module frame_scaler #(
    parameter int unsigned SRC_W        = 160,
    parameter int unsigned SRC_H        = 144,
    parameter int unsigned PIX_BITS     = 2,
    parameter int unsigned SCALE_LOG2   = 1,
    parameter int unsigned X_OFFSET     = 160,
    parameter int unsigned Y_OFFSET     = 76,
    parameter logic [23:0] BORDER_COLOR = 24'h000000
) (
    input  logic                gpuclk,
    input  logic                gpuclk_rst_b,
    frame_scaler_if.slave       pix,
    input  logic                pal_we,
    input  logic [PIX_BITS-1:0] pal_addr,
    input  logic [23:0]         pal_data,
    input  logic [9:0]          x,
    input  logic [9:0]          y,
    input  logic                hs,
    input  logic                vs,
    input  logic                border,
    output logic [23:0]         color,
    output logic                hsync,
    output logic                vsync,
    output logic                blank_b,
    output logic                frame_swapped,
    output logic                frame_dropped
);

    localparam int unsigned NPIX  = SRC_W * SRC_H;
    localparam int unsigned AW    = $clog2(NPIX);
    localparam int unsigned CW    = $clog2(NPIX + 1);
    localparam int unsigned NPAL  = 1 << PIX_BITS;
    localparam int unsigned WIN_W = SRC_W << SCALE_LOG2;
    localparam int unsigned WIN_H = SRC_H << SCALE_LOG2;

    localparam logic [9:0]    X_LO   = 10'(X_OFFSET);
    localparam logic [9:0]    X_HI   = 10'(X_OFFSET + WIN_W);
    localparam logic [9:0]    Y_LO   = 10'(Y_OFFSET);
    localparam logic [9:0]    Y_HI   = 10'(Y_OFFSET + WIN_H);
    localparam logic [CW-1:0] CNT_LAST = CW'(NPIX - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(NPIX);

    // Gray ramp from white (entry 0) down to black (last entry).
    function automatic logic [23:0] pal_reset(input int unsigned i);
        int unsigned g;
        g = ((NPAL - 1 - i) * 255) / (NPAL - 1);
        return {3{8'(g)}};
    endfunction

    // Frame bookkeeping state
    logic          front_sel_q,   front_sel_d;
    logic          back_full_q,   back_full_d;
    logic          front_valid_q, front_valid_d;
    logic [CW-1:0] wr_cnt_q,      wr_cnt_d;
    logic          swap_c, drop_c, wr_en_c, wr_buf_c;
    logic [AW-1:0] wr_addr_c;

    // Swap / write control; the write target follows a same-cycle swap.
    always_comb begin
        swap_c        = back_full_q && (x == 10'd0) && (y == Y_HI);
        front_sel_d   = front_sel_q ^ swap_c;
        front_valid_d = front_valid_q | swap_c;
        back_full_d   = back_full_q & ~swap_c;
        wr_cnt_d      = wr_cnt_q;
        wr_addr_c     = AW'(wr_cnt_q);
        wr_en_c       = 1'b0;
        drop_c        = 1'b0;
        if (pix.in_valid) begin
            if (pix.in_sof) begin
                wr_en_c     = 1'b1;
                wr_addr_c   = '0;
                wr_cnt_d    = CW'(1);
                back_full_d = 1'b0;
                // A frame consumed by a coinciding swap is shown, not dropped.
                drop_c      = back_full_q & ~swap_c;
            end else if (wr_cnt_q < CNT_FULL) begin
                wr_en_c  = 1'b1;
                wr_cnt_d = wr_cnt_q + CW'(1);
                if (wr_cnt_q == CNT_LAST) begin
                    back_full_d = 1'b1;
                end
            end
        end
        wr_buf_c = ~front_sel_d;
    end

    // Read address from raster position
    logic          in_win_c;
    logic [9:0]    sx_c, sy_c;
    logic [AW-1:0] rd_addr_c;

    always_comb begin
        in_win_c  = (x >= X_LO) && (x < X_HI) && (y >= Y_LO) && (y < Y_HI);
        sx_c      = 10'(x - X_LO) >> SCALE_LOG2;
        sy_c      = 10'(y - Y_LO) >> SCALE_LOG2;
        rd_addr_c = '0;
        if (in_win_c) begin
            rd_addr_c = AW'(sy_c) * AW'(SRC_W) + AW'(sx_c);
        end
    end

    // Ping-pong frame RAMs, synchronous read, contents survive reset
    logic [PIX_BITS-1:0] mem0 [NPIX];
    logic [PIX_BITS-1:0] mem1 [NPIX];
    logic [PIX_BITS-1:0] rd0_q, rd1_q;

    always_ff @(posedge gpuclk) begin
        if (wr_en_c && !wr_buf_c) begin
            mem0[wr_addr_c] <= pix.in_data;
        end
        if (wr_en_c && wr_buf_c) begin
            mem1[wr_addr_c] <= pix.in_data;
        end
        rd0_q <= mem0[rd_addr_c];
        rd1_q <= mem1[rd_addr_c];
    end

    // Palette
    logic [23:0] pal_q [NPAL];

    always_ff @(posedge gpuclk or negedge gpuclk_rst_b) begin
        if (!gpuclk_rst_b) begin
            for (int i = 0; i < NPAL; i++) begin
                pal_q[PIX_BITS'(i)] <= pal_reset(i);
            end
        end else if (pal_we) begin
            pal_q[pal_addr] <= pal_data;
        end
    end

    // Control state register
    always_ff @(posedge gpuclk or negedge gpuclk_rst_b) begin
        if (!gpuclk_rst_b) begin
            front_sel_q   <= 1'b0;
            back_full_q   <= 1'b0;
            front_valid_q <= 1'b0;
            wr_cnt_q      <= '0;
        end else begin
            front_sel_q   <= front_sel_d;
            back_full_q   <= back_full_d;
            front_valid_q <= front_valid_d;
            wr_cnt_q      <= wr_cnt_d;
        end
    end

    // Stage 1: decisions and syncs aligned with the RAM read
    logic win1_q, fv1_q, sel1_q, hs1_q, vs1_q, bd1_q;

    always_ff @(posedge gpuclk or negedge gpuclk_rst_b) begin
        if (!gpuclk_rst_b) begin
            win1_q <= 1'b0;
            fv1_q  <= 1'b0;
            sel1_q <= 1'b0;
            hs1_q  <= 1'b1;
            vs1_q  <= 1'b1;
            bd1_q  <= 1'b1;
        end else begin
            win1_q <= in_win_c;
            fv1_q  <= front_valid_q;
            sel1_q <= front_sel_q;
            hs1_q  <= hs;
            vs1_q  <= vs;
            bd1_q  <= border;
        end
    end

    // Stage 2: palette lookup
    logic [PIX_BITS-1:0] code_c;
    logic [23:0]         color_d;

    always_comb begin
        code_c  = '0;
        color_d = BORDER_COLOR;
        if (fv1_q) begin
            code_c = sel1_q ? rd1_q : rd0_q;
        end
        if (bd1_q) begin
            color_d = 24'h000000;
        end else if (win1_q) begin
            color_d = pal_q[code_c];
        end
    end

    logic [23:0] color_q;
    logic        hs2_q, vs2_q, blank_q, swapped_q, dropped_q;

    always_ff @(posedge gpuclk or negedge gpuclk_rst_b) begin
        if (!gpuclk_rst_b) begin
            color_q   <= '0;
            hs2_q     <= 1'b1;
            vs2_q     <= 1'b1;
            blank_q   <= 1'b0;
            swapped_q <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            color_q   <= color_d;
            hs2_q     <= hs1_q;
            vs2_q     <= vs1_q;
            blank_q   <= ~bd1_q;
            swapped_q <= swap_c;
            dropped_q <= drop_c;
        end
    end

    assign color         = color_q;
    assign hsync         = hs2_q;
    assign vsync         = vs2_q;
    assign blank_b       = blank_q;
    assign frame_swapped = swapped_q;
    assign frame_dropped = dropped_q;

endmodule
